sigmoid_pio_responder: RTL and testbench



---
 rtl/sigmoid_pio_responder.sv | 208 ++++++++++++++++++++
 tb/tb_sigmoid_pio_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pio_responder.sv
// PIO responder: serves sig (PLAN sigmoid) and isig (sigmoid derivative) on a shared engine.
// Optional sticky overrun flag in bit 29 is built when SIGMOID_OVERRUN_EN is defined.
module sigmoid_pio_responder #(
  parameter int DATA_W   = 16,
  parameter int FRAC     = 12,
  parameter int MUL_ITER = 13
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] sig_req_word,
  input  logic [31:0] isig_req_word,
  output logic [31:0] sig_rsp_word,
  output logic [31:0] isig_rsp_word
);

  localparam int ITER_W = $clog2(MUL_ITER + 1);

  localparam logic [DATA_W-1:0] ONE     = DATA_W'(2 ** FRAC);
  localparam logic [DATA_W-1:0] BP_SAT  = DATA_W'(5 * (2 ** FRAC));
  localparam logic [DATA_W-1:0] BP_HI   = DATA_W'(19 * (2 ** (FRAC - 3)));
  localparam logic [DATA_W-1:0] OFS_HI  = DATA_W'(27 * (2 ** (FRAC - 5)));
  localparam logic [DATA_W-1:0] OFS_MID = DATA_W'(5 * (2 ** (FRAC - 3)));
  localparam logic [DATA_W-1:0] OFS_LO  = DATA_W'(2 ** (FRAC - 1));
  localparam logic [DATA_W-1:0] X_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] X_MAX   = {1'b0, {(DATA_W-1){1'b1}}};

  localparam logic CH_SIG  = 1'b0;
  localparam logic CH_ISIG = 1'b1;

  typedef enum logic [1:0] {IDLE, PLAN, MUL, DONE} state_t;

  logic [1:0][31:0]       req_in;
  logic [1:0][31:0]       rsp_word;
  logic [1:0]             req_bit;
  logic [1:0][DATA_W-1:0] req_x;
  logic [1:0]             pending;
  logic [1:0]             ovr_bit;

  state_t                 state_reg;
  logic                   chan_reg;
  logic [DATA_W-1:0]      x_reg;
  logic [DATA_W-1:0]      y_reg;
  logic [2*DATA_W-1:0]    acc_reg;
  logic [2*DATA_W-1:0]    mcand_reg;
  logic [DATA_W-1:0]      mplier_reg;
  logic [ITER_W-1:0]      iter_reg;
  logic [1:0]             ack_reg;
  logic [1:0]             busy_reg;
  logic [1:0][DATA_W-1:0] result_reg;

  logic [DATA_W-1:0]      plan_a;
  logic [DATA_W-1:0]      plan_y_abs;
  logic [DATA_W-1:0]      plan_y;
  logic                   unused_acc;

`ifdef SIGMOID_OVERRUN_EN
  logic [1:0]             tog;
  logic [1:0]             ovr_reg;
  logic                   toggle_seen_reg;
  assign ovr_bit = ovr_reg;
`else
  assign ovr_bit = 2'b00;
`endif

  assign req_in        = {isig_req_word, sig_req_word};
  assign sig_rsp_word  = rsp_word[0];
  assign isig_rsp_word = rsp_word[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [31:0] req_q;
      logic        unused_req;

      always_ff @(posedge clk_clk) begin
        req_q <= req_in[gi];
      end

      assign req_bit[gi]  = req_q[31];
      assign req_x[gi]    = req_q[DATA_W-1:0];
      assign unused_req   = ^req_q[30:DATA_W];
      assign pending[gi]  = req_bit[gi] ^ ack_reg[gi];
      assign rsp_word[gi] = {ack_reg[gi], busy_reg[gi], ovr_bit[gi],
                             {(29-DATA_W){1'b0}}, result_reg[gi]};

`ifdef SIGMOID_OVERRUN_EN
      // Edge detect on the registered toggle bit, so every flip counts once.
      logic req_d_reg;
      always_ff @(posedge clk_clk) begin
        req_d_reg <= req_q[31];
      end
      assign tog[gi] = req_q[31] ^ req_d_reg;
`endif
    end
  endgenerate

  // Piecewise-linear sigmoid on |x|; the most negative input saturates like a large magnitude.
  always_comb begin
    plan_a = x_reg;
    if (x_reg == X_MIN) begin
      plan_a = X_MAX;
    end else if (x_reg[DATA_W-1]) begin
      plan_a = DATA_W'(0) - x_reg;
    end

    if (plan_a >= BP_SAT) begin
      plan_y_abs = ONE;
    end else if (plan_a >= BP_HI) begin
      plan_y_abs = (plan_a >> 5) + OFS_HI;
    end else if (plan_a >= ONE) begin
      plan_y_abs = (plan_a >> 3) + OFS_MID;
    end else begin
      plan_y_abs = (plan_a >> 2) + OFS_LO;
    end

    plan_y = x_reg[DATA_W-1] ? (ONE - plan_y_abs) : plan_y_abs;
  end

  assign unused_acc = ^{acc_reg[FRAC-1:0], acc_reg[2*DATA_W-1:FRAC+DATA_W]};

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg  <= IDLE;
      chan_reg   <= CH_SIG;
      x_reg      <= '0;
      y_reg      <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      iter_reg   <= '0;
      // Load acks from the live ports so a toggle left over from before reset is ignored.
      ack_reg    <= {isig_req_word[31], sig_req_word[31]};
      busy_reg   <= 2'b00;
      result_reg <= '0;
`ifdef SIGMOID_OVERRUN_EN
      ovr_reg         <= 2'b00;
      toggle_seen_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
`ifdef SIGMOID_OVERRUN_EN
          toggle_seen_reg <= 1'b0;
`endif
          if (pending[0]) begin
            x_reg             <= req_x[0];
            chan_reg          <= CH_SIG;
            busy_reg[CH_SIG]  <= 1'b1;
            state_reg         <= PLAN;
          end else if (pending[1]) begin
            x_reg             <= req_x[1];
            chan_reg          <= CH_ISIG;
            busy_reg[CH_ISIG] <= 1'b1;
            state_reg         <= PLAN;
          end
        end

        PLAN: begin
          y_reg      <= plan_y;
          acc_reg    <= '0;
          mcand_reg  <= {{DATA_W{1'b0}}, plan_y};
          mplier_reg <= ONE - plan_y;
          iter_reg   <= '0;
          state_reg  <= (chan_reg == CH_ISIG) ? MUL : DONE;
        end

        MUL: begin
          if (mplier_reg[0]) begin
            acc_reg <= acc_reg + mcand_reg;
          end
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          iter_reg   <= iter_reg + ITER_W'(1);
          if (iter_reg == ITER_W'(MUL_ITER - 1)) begin
            state_reg <= DONE;
          end
        end

        DONE: begin
          result_reg[chan_reg] <= (chan_reg == CH_ISIG) ? acc_reg[FRAC +: DATA_W] : y_reg;
          ack_reg[chan_reg]    <= req_bit[chan_reg];
          busy_reg[chan_reg]   <= 1'b0;
`ifdef SIGMOID_OVERRUN_EN
          if (!toggle_seen_reg && !tog[chan_reg]) begin
            ovr_reg[chan_reg] <= 1'b0;
          end
`endif
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase

`ifdef SIGMOID_OVERRUN_EN
      // A flip while busy is an overrun; the setting wins over any clear in DONE.
      for (int ch = 0; ch < 2; ch++) begin
        if (busy_reg[ch] && tog[ch]) begin
          ovr_reg[ch] <= 1'b1;
        end
      end
      if (busy_reg[chan_reg] && tog[chan_reg]) begin
        toggle_seen_reg <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sigmoid_pio_responder.sv
// Scoreboard bench for sigmoid_pio_responder: stimulus queues expected ack words,
// a negedge monitor pops and compares them whenever an ack bit flips.
module tb_sigmoid_pio_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [31:0] sig_req_word;
  logic [31:0] isig_req_word;
  logic [31:0] sig_rsp_word;
  logic [31:0] isig_rsp_word;

  sigmoid_pio_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .sig_req_word  (sig_req_word),
    .isig_req_word (isig_req_word),
    .sig_rsp_word  (sig_rsp_word),
    .isig_rsp_word (isig_rsp_word)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  exp_t        exp_q [2][$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        sig_req_bit;
  logic        isig_req_bit;
  logic [31:0] prev_sig;
  logic [31:0] prev_isig;

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", name, got, req);
    end else begin
      $display("ok   %s: %08h", name, got);
    end
  endtask

  task automatic check_ack(input int ch, input logic [31:0] word);
    exp_t  e;
    string name;
    name = (ch == 0) ? "sig_ack" : "isig_ack";
    checks++;
    if (exp_q[ch].size() == 0) begin
      errors++;
      $display("FAIL %s unexpected: got %08h at cycle %0d required no ack", name, word, cyc);
    end else begin
      e = exp_q[ch].pop_front();
      if (word !== e.word || cyc != e.due) begin
        errors++;
        $display("FAIL %s: got %08h at cycle %0d required %08h at cycle %0d",
                 name, word, cyc, e.word, e.due);
      end else begin
        $display("ok   %s: %08h at cycle %0d", name, word, cyc);
      end
    end
  endtask

  // Monitor: a flipped ack bit is the DUT presenting a response.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (sig_rsp_word[31] !== prev_sig[31]) check_ack(0, sig_rsp_word);
      if (isig_rsp_word[31] !== prev_isig[31]) check_ack(1, isig_rsp_word);
    end
    prev_sig  <= sig_rsp_word;
    prev_isig <= isig_rsp_word;
  end

  task automatic send(input int ch, input logic [15:0] x, input logic [15:0] res,
                      input int lat, input bit expect_ack);
    exp_t e;
    logic b;
    if (ch == 0) begin
      sig_req_bit  = ~sig_req_bit;
      sig_req_word = {sig_req_bit, 15'b0, x};
      b = sig_req_bit;
    end else begin
      isig_req_bit  = ~isig_req_bit;
      isig_req_word = {isig_req_bit, 15'b0, x};
      b = isig_req_bit;
    end
    if (expect_ack) begin
      e.word = {b, 2'b00, 13'b0, res};
      e.due  = cyc + lat;
      exp_q[ch].push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      tick();
    end
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d outstanding required 0/0",
               exp_q[0].size(), exp_q[1].size());
      exp_q[0].delete();
      exp_q[1].delete();
    end
    tick();
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tick();
    tick();
    reset_reset = 1'b0;
  endtask

  logic [15:0] sig_x   [6] = '{16'h0000, 16'h1000, 16'hF000, 16'h3000, 16'h6000, 16'h8000};
  logic [15:0] sig_res [6] = '{16'h0800, 16'h0C00, 16'h0400, 16'h0F00, 16'h1000, 16'h0000};
  logic        ovr_exp;

  initial begin
`ifdef SIGMOID_OVERRUN_EN
    ovr_exp = 1'b1;
`else
    ovr_exp = 1'b0;
`endif
    reset_reset   = 1'b1;
    sig_req_bit   = 1'b1;
    isig_req_bit  = 1'b0;
    sig_req_word  = 32'h8000_0000;
    isig_req_word = 32'h0000_0000;
    do_reset();
    repeat (10) tick();
    chk("reset_sig_rsp", sig_rsp_word, 32'h8000_0000);
    chk("reset_isig_rsp", isig_rsp_word, 32'h0000_0000);

    for (int i = 0; i < 6; i++) begin
      send(0, sig_x[i], sig_res[i], 4, 1'b1);
      drain();
    end

    send(1, 16'h0000, 16'h0400, 17, 1'b1);
    drain();
    send(1, 16'h6000, 16'h0000, 17, 1'b1);
    drain();

    send(0, 16'h1000, 16'h0C00, 4, 1'b1);
    send(1, 16'h1000, 16'h0300, 20, 1'b1);
    drain();

    // Abandon an isig operation mid-multiply.
    send(1, 16'h0000, 16'h0000, 17, 1'b0);
    repeat (8) tick();
    chk("isig_busy_in_mul", {31'b0, isig_rsp_word[30]}, 32'h1);
    do_reset();
    chk("isig_after_reset", isig_rsp_word, {isig_req_bit, 31'b0});
    chk("sig_after_reset", sig_rsp_word, {sig_req_bit, 31'b0});
    repeat (25) tick();
    send(1, 16'h0000, 16'h0400, 17, 1'b1);
    drain();

    // Two sig toggles one cycle apart: even count, no visible ack.
    send(0, 16'h1000, 16'h0000, 4, 1'b0);
    tick();
    send(0, 16'h1000, 16'h0000, 4, 1'b0);
    repeat (8) tick();
    chk("overrun_set", {31'b0, sig_rsp_word[29]}, {31'b0, ovr_exp});
    chk("double_toggle_ack", {31'b0, sig_rsp_word[31]}, {31'b0, sig_req_bit});
    chk("double_toggle_result", {16'b0, sig_rsp_word[15:0]}, 32'h0000_0C00);
    send(0, 16'h0000, 16'h0800, 4, 1'b1);
    drain();
    chk("overrun_cleared", {31'b0, sig_rsp_word[29]}, 32'h0);
    chk("isig_zero_field", {19'b0, isig_rsp_word[28:16]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
